// File: rtl/uart_reg_ctrl.sv
// UART register file and sequencing controller: SR/CR/RXDR/TXDR, RX capture
// with overrun/parity flags, and the TX launch FSM that drives the tx_frontend.
module uart_reg_ctrl #(
  parameter logic [15:0] CLK_DIV_RESET = 16'd868,
  parameter logic        DS_RESET      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  addr_i,
  input  logic        read_i,
  output logic [31:0] read_data_o,
  input  logic        write_i,
  input  logic [31:0] write_data_i,
  input  logic [10:0] rx_frame_i,
  input  logic        rx_parity_i,
  input  logic        rx_valid_i,
  output logic        tx_transmit_o,
  output logic [7:0]  tx_dr_o,
  input  logic        tx_done_i,
  output logic [15:0] cr_clk_div_o,
  output logic        cr_ds_o,
  output logic        cr_s_o,
  output logic [1:0]  cr_p_o
);

  localparam logic [1:0] REG_SR   = 2'd0;
  localparam logic [1:0] REG_CR   = 2'd1;
  localparam logic [1:0] REG_RXDR = 2'd2;
  localparam logic [1:0] REG_TXDR = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_BUSY
  } tx_state_t;

  tx_state_t tx_state;
  tx_state_t tx_next;
  logic      tx_launch;

  logic        rxne;
  logic        pe;
  logic        ovr;
  logic        txe;
  logic [7:0]  rxdr;
  logic [7:0]  txdr;
  logic [15:0] cr_clk_div;
  logic        cr_ds;
  logic        cr_s;
  logic [1:0]  cr_p;

  logic        addr_ok;
  logic [1:0]  reg_sel;
  logic        rd_rxdr;
  logic        wr_sr;
  logic        wr_cr;
  logic        wr_txdr;
  logic        rx_load;
  logic        rx_overrun;
  logic [7:0]  rx_byte;
  logic [31:0] rdata;
  logic        unused_bits;

  // Only the four word-aligned addresses in the low nibble map to registers.
  assign addr_ok = (addr_i[7:4] == 4'd0) && (addr_i[1:0] == 2'd0);
  assign reg_sel = addr_i[3:2];
  assign rd_rxdr = read_i  && addr_ok && (reg_sel == REG_RXDR);
  assign wr_sr   = write_i && addr_ok && (reg_sel == REG_SR);
  assign wr_cr   = write_i && addr_ok && (reg_sel == REG_CR);
  assign wr_txdr = write_i && addr_ok && (reg_sel == REG_TXDR);

  // TXE is exactly "no frame in flight", so it falls out of the FSM state.
  assign txe = (tx_state == TX_IDLE);

  // A frame is accepted when RXDR is empty or is being drained this cycle.
  assign rx_load    = rx_valid_i && (!rxne || rd_rxdr);
  assign rx_overrun = rx_valid_i && rxne && !rd_rxdr;
  assign rx_byte    = {rx_frame_i[7] & cr_ds, rx_frame_i[6:0]};

  assign unused_bits = ^{write_data_i[15:8], rx_frame_i[10:8]};

  always_comb begin
    rdata = 32'd0;
    if (addr_ok) begin
      case (reg_sel)
        REG_SR:   rdata = {28'd0, ovr, pe, txe, rxne};
        REG_CR:   rdata = {cr_clk_div, 11'd0, cr_ds, cr_s, cr_p, 1'b0};
        REG_RXDR: rdata = {24'd0, rxdr};
        REG_TXDR: rdata = {24'd0, txdr};
        default:  rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    tx_next   = tx_state;
    tx_launch = 1'b0;
    case (tx_state)
      TX_IDLE:   if (wr_txdr) tx_next = TX_LAUNCH;
      TX_LAUNCH: begin
        tx_launch = 1'b1;
        tx_next   = TX_BUSY;
      end
      TX_BUSY:   if (tx_done_i) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state      <= TX_IDLE;
      tx_transmit_o <= 1'b0;
      read_data_o   <= 32'd0;
      rxne          <= 1'b0;
      pe            <= 1'b0;
      ovr           <= 1'b0;
      rxdr          <= 8'd0;
      txdr          <= 8'd0;
      cr_clk_div    <= CLK_DIV_RESET;
      cr_ds         <= DS_RESET;
      cr_s          <= 1'b0;
      cr_p          <= 2'd0;
    end else begin
      tx_state      <= tx_next;
      tx_transmit_o <= tx_launch;

      if (read_i)
        read_data_o <= rdata;

      if (rx_load)
        rxdr <= rx_byte;
      if (rx_load)
        rxne <= 1'b1;
      else if (rd_rxdr)
        rxne <= 1'b0;

      // Set events win over a simultaneous write-1-to-clear.
      pe  <= (rx_load && rx_parity_i) || (pe && !(wr_sr && write_data_i[2]));
      ovr <= rx_overrun || (ovr && !(wr_sr && write_data_i[3]));

      if (wr_txdr && txe)
        txdr <= write_data_i[7:0];

      // Frame format is frozen while a frame is being launched or sent.
      if (wr_cr && txe) begin
        cr_clk_div <= write_data_i[31:16];
        cr_ds      <= write_data_i[4];
        cr_s       <= write_data_i[3];
        cr_p       <= write_data_i[2:1];
      end
    end
  end

  assign tx_dr_o      = txdr;
  assign cr_clk_div_o = cr_clk_div;
  assign cr_ds_o      = cr_ds;
  assign cr_s_o       = cr_s;
  assign cr_p_o       = cr_p;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a register-level model.
module tb_uart_reg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  addr_i = 8'd0;
  logic        read_i = 1'b0;
  logic [31:0] read_data_o;
  logic        write_i = 1'b0;
  logic [31:0] write_data_i = 32'd0;
  logic [10:0] rx_frame_i = 11'd0;
  logic        rx_parity_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic        tx_transmit_o;
  logic [7:0]  tx_dr_o;
  logic        tx_done_i = 1'b0;
  logic [15:0] cr_clk_div_o;
  logic        cr_ds_o;
  logic        cr_s_o;
  logic [1:0]  cr_p_o;

  always #5 clk_i = ~clk_i;

  uart_reg_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .read_i       (read_i),
    .read_data_o  (read_data_o),
    .write_i      (write_i),
    .write_data_i (write_data_i),
    .rx_frame_i   (rx_frame_i),
    .rx_parity_i  (rx_parity_i),
    .rx_valid_i   (rx_valid_i),
    .tx_transmit_o(tx_transmit_o),
    .tx_dr_o      (tx_dr_o),
    .tx_done_i    (tx_done_i),
    .cr_clk_div_o (cr_clk_div_o),
    .cr_ds_o      (cr_ds_o),
    .cr_s_o       (cr_s_o),
    .cr_p_o       (cr_p_o)
  );

  localparam logic [31:0] C0 = 32'h0364_0010;
  localparam logic [31:0] C1 = 32'h0364_0000;
  localparam logic [31:0] C2 = 32'h0010_0008;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        rxv;
    logic [10:0] frame;
    logic        par;
    logic        done;
    logic [31:0] exp_rd;
    logic        exp_tx;
    logic [7:0]  exp_dr;
    logic [31:0] exp_cr;
  } vec_t;

  vec_t tbl[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: register contents plus "frame in flight since cycle".
  logic        m_rxne, m_pe, m_ovr, m_busy, m_tx;
  logic [7:0]  m_rxdr, m_txdr;
  logic [31:0] m_cr, m_rd;
  int          m_cyc, m_wc;

  task automatic addVec(input logic r, rd, wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic rv, input logic [10:0] fr, input logic pa, input logic dn,
                        input logic [31:0] erd, input logic etx, input logic [7:0] edr,
                        input logic [31:0] ecr);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
    v.rxv = rv; v.frame = fr; v.par = pa; v.done = dn;
    v.exp_rd = erd; v.exp_tx = etx; v.exp_dr = edr; v.exp_cr = ecr;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, rd, wr, input logic [7:0] a, input logic [31:0] wd,
                               input logic rv, input logic [10:0] fr, input logic pa, input logic dn);
    rst_i = r; read_i = rd; write_i = wr; addr_i = a; write_data_i = wd;
    rx_valid_i = rv; rx_frame_i = fr; rx_parity_i = pa; tx_done_i = dn;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] erd, input logic etx,
                             input logic [7:0] edr, input logic [31:0] ecr);
    logic [31:0] gcr;
    gcr = {cr_clk_div_o, 11'd0, cr_ds_o, cr_s_o, cr_p_o, 1'b0};
    vectors++;
    if (read_data_o !== erd || tx_transmit_o !== etx || tx_dr_o !== edr || gcr !== ecr) begin
      miscompares++;
      $display("[TB] FAIL %s: got rd=%h tx=%b dr=%h cr=%h, expected rd=%h tx=%b dr=%h cr=%h",
               name, read_data_o, tx_transmit_o, tx_dr_o, gcr, erd, etx, edr, ecr);
    end
  endtask

  task automatic modelReset();
    m_rxne = 0; m_pe = 0; m_ovr = 0; m_busy = 0; m_tx = 0;
    m_rxdr = 0; m_txdr = 0; m_cr = C0; m_rd = 0; m_cyc = 0; m_wc = -10;
  endtask

  function automatic logic [31:0] modelReg(input logic [7:0] a);
    case (a)
      8'h00:   return {28'd0, m_ovr, m_pe, !m_busy, m_rxne};
      8'h04:   return m_cr;
      8'h08:   return {24'd0, m_rxdr};
      8'h0C:   return {24'd0, m_txdr};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input logic r, rd, wr, input logic [7:0] a, input logic [31:0] wd,
                           input logic rv, input logic [10:0] fr, input logic pa, input logic dn);
    logic [31:0] n_rd;
    logic n_tx, rd_rx, load, ovr_set, wsr;
    if (r) begin
      modelReset();
    end else begin
      n_rd    = rd ? modelReg(a) : m_rd;
      n_tx    = m_busy && (m_cyc == m_wc + 1);
      rd_rx   = rd && (a == 8'h08);
      load    = rv && (!m_rxne || rd_rx);
      ovr_set = rv && m_rxne && !rd_rx;
      wsr     = wr && (a == 8'h00);
      if (load) m_rxdr = m_cr[4] ? fr[7:0] : {1'b0, fr[6:0]};
      m_rxne = load ? 1'b1 : (rd_rx ? 1'b0 : m_rxne);
      m_pe   = (load && pa) || (m_pe && !(wsr && wd[2]));
      m_ovr  = ovr_set || (m_ovr && !(wsr && wd[3]));
      if (wr && a == 8'h04 && !m_busy) m_cr = wd & 32'hFFFF_001E;
      if (wr && a == 8'h0C && !m_busy) begin
        m_txdr = wd[7:0]; m_busy = 1; m_wc = m_cyc;
      end else if (m_busy && dn && m_cyc >= m_wc + 2) begin
        m_busy = 0;
      end
      m_rd = n_rd;
      m_tx = n_tx;
    end
    m_cyc++;
  endtask

  initial begin
    logic r, rd, wr, rv, pa, dn;
    logic [7:0] a;
    logic [1:0] sel;
    logic [31:0] wd;
    logic [10:0] fr;
    int op;

    $display("[TB] starting uart_reg_ctrl bench");

    //     rst rd wr addr   wdata          rxv frame    par dn  exp_rd         tx dr     cr
    addVec(1, 0, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h0,         0, 8'h00, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h2,         0, 8'h00, C0);
    addVec(0, 1, 0, 8'h04, 32'h0,         0, 11'h0,   0, 0,  C0,            0, 8'h00, C0);
    addVec(0, 0, 1, 8'h0C, 32'h5A,        0, 11'h0,   0, 0,  C0,            0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h0,         1, 8'h5A, C0);
    addVec(0, 0, 1, 8'h0C, 32'hA5,        0, 11'h0,   0, 0,  32'h0,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h0C, 32'h0,         0, 11'h0,   0, 0,  32'h5A,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 1,  32'h0,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h2,         0, 8'h5A, C0);
    addVec(0, 0, 0, 8'h00, 32'h0,         1, 11'h0C3, 0, 0,  32'h2,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h3,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h08, 32'h0,         0, 11'h0,   0, 0,  32'hC3,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h2,         0, 8'h5A, C0);
    addVec(0, 0, 1, 8'h04, C1,            0, 11'h0,   0, 0,  32'h2,         0, 8'h5A, C1);
    addVec(0, 0, 0, 8'h00, 32'h0,         1, 11'h0C3, 0, 0,  32'h2,         0, 8'h5A, C1);
    addVec(0, 1, 0, 8'h08, 32'h0,         0, 11'h0,   0, 0,  32'h43,        0, 8'h5A, C1);
    addVec(0, 0, 1, 8'h04, C0,            0, 11'h0,   0, 0,  32'h43,        0, 8'h5A, C0);
    addVec(0, 0, 0, 8'h00, 32'h0,         1, 11'h011, 0, 0,  32'h43,        0, 8'h5A, C0);
    addVec(0, 0, 0, 8'h00, 32'h0,         1, 11'h022, 0, 0,  32'h43,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'hB,         0, 8'h5A, C0);
    addVec(0, 0, 1, 8'h00, 32'h8,         0, 11'h0,   0, 0,  32'hB,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h3,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h08, 32'h0,         1, 11'h022, 0, 0,  32'h11,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h3,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h08, 32'h0,         0, 11'h0,   0, 0,  32'h22,        0, 8'h5A, C0);
    addVec(0, 0, 0, 8'h00, 32'h0,         1, 11'h033, 1, 0,  32'h22,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h7,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h08, 32'h0,         0, 11'h0,   0, 0,  32'h33,        0, 8'h5A, C0);
    addVec(0, 0, 1, 8'h00, 32'h4,         1, 11'h044, 1, 0,  32'h33,        0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h7,         0, 8'h5A, C0);
    addVec(0, 0, 1, 8'h00, 32'h4,         0, 11'h0,   0, 0,  32'h7,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h00, 32'h0,         0, 11'h0,   0, 0,  32'h3,         0, 8'h5A, C0);
    addVec(0, 1, 0, 8'h08, 32'h0,         0, 11'h0,   0, 0,  32'h44,        0, 8'h5A, C0);
    addVec(0, 0, 1, 8'h0C, 32'h77,        0, 11'h0,   0, 0,  32'h44,        0, 8'h77, C0);
    addVec(0, 0, 1, 8'h04, C2,            0, 11'h0,   0, 0,  32'h44,        1, 8'h77, C0);
    addVec(0, 1, 0, 8'h04, 32'h0,         0, 11'h0,   0, 0,  C0,            0, 8'h77, C0);
    addVec(0, 0, 1, 8'h04, C2,            0, 11'h0,   0, 0,  C0,            0, 8'h77, C0);
    addVec(0, 1, 0, 8'h04, 32'h0,         0, 11'h0,   0, 0,  C0,            0, 8'h77, C0);
    addVec(0, 0, 0, 8'h00, 32'h0,         0, 11'h0,   0, 1,  C0,            0, 8'h77, C0);
    addVec(0, 0, 1, 8'h04, C2,            0, 11'h0,   0, 0,  C0,            0, 8'h77, C2);
    addVec(0, 1, 0, 8'h04, 32'h0,         0, 11'h0,   0, 0,  C2,            0, 8'h77, C2);
    addVec(0, 1, 0, 8'h10, 32'h0,         0, 11'h0,   0, 0,  32'h0,         0, 8'h77, C2);
    addVec(0, 0, 1, 8'h14, 32'hFFFFFFFF,  0, 11'h0,   0, 0,  32'h0,         0, 8'h77, C2);
    addVec(0, 0, 1, 8'h05, 32'hFFFFFFFF,  0, 11'h0,   0, 0,  32'h0,         0, 8'h77, C2);
    addVec(0, 1, 0, 8'h04, 32'h0,         0, 11'h0,   0, 0,  C2,            0, 8'h77, C2);
    addVec(0, 1, 0, 8'h14, 32'h0,         0, 11'h0,   0, 0,  32'h0,         0, 8'h77, C2);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                    tbl[i].rxv, tbl[i].frame, tbl[i].par, tbl[i].done);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_rd, tbl[i].exp_tx, tbl[i].exp_dr, tbl[i].exp_cr);
    end

    // Reset one cycle after a TXDR write must cancel the pending launch.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    checkOutput("midrst_reset", 32'h0, 0, 8'h00, C0);
    applyStimulus(0, 0, 1, 8'h0C, 32'h3C, 0, 11'h0, 0, 0);
    checkOutput("midrst_write", 32'h0, 0, 8'h3C, C0);
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    checkOutput("midrst_abort", 32'h0, 0, 8'h00, C0);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 1);
    checkOutput("midrst_done", 32'h0, 0, 8'h00, C0);
    applyStimulus(0, 1, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    checkOutput("midrst_txe", 32'h2, 0, 8'h00, C0);

    // tx_done during the launch cycle is not the end of the frame.
    applyStimulus(0, 0, 1, 8'h0C, 32'h3C, 0, 11'h0, 0, 0);
    checkOutput("launch_write", 32'h2, 0, 8'h3C, C0);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 1);
    checkOutput("launch_done", 32'h2, 1, 8'h3C, C0);
    applyStimulus(0, 1, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    checkOutput("launch_busy", 32'h0, 0, 8'h3C, C0);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 1);
    checkOutput("busy_done", 32'h0, 0, 8'h3C, C0);
    applyStimulus(0, 1, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    checkOutput("done_idle", 32'h2, 0, 8'h3C, C0);

    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    modelReset();
    checkOutput("rand_reset", m_rd, m_tx, m_txdr, m_cr);

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      op  = $urandom_range(0, 3);
      rd  = (op == 1);
      wr  = (op >= 2);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      else a = {4'd0, sel, 2'b00};
      wd  = $urandom;
      rv  = ($urandom_range(0, 3) == 0);
      fr  = 11'($urandom);
      pa  = ($urandom_range(0, 5) == 0);
      dn  = ($urandom_range(0, 3) == 0);
      applyStimulus(r, rd, wr, a, wd, rv, fr, pa, dn);
      modelStep(r, rd, wr, a, wd, rv, fr, pa, dn);
      checkOutput($sformatf("rand%0d", i), m_rd, m_tx, m_txdr, m_cr);
    end

    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 11'h0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
